// File: rtl/serial_subtractor_ctrl.sv
// rtl/serial_subtractor_ctrl.sv - bit-serial WIDTH-bit subtractor (A-B) from two cascaded half-subtractors
// Optional macro SERIAL_SUB_CLAMP_EN: clamp diff to 0 on underflow, borrow_out stays the underflow flag.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa, sb, res, res_next;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             t, br1, d, br2, br_next;

  // Operand stage feeds the borrow stage; the held borrow ripples bit to bit.
  always_comb begin
    t        = sa[0] ^ sb[0];
    br1      = ~sa[0] & sb[0];
    d        = t ^ br;
    br2      = ~t & br;
    br_next  = br1 | br2;
    res_next = res >> 1;
    res_next[WIDTH-1] = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa         <= a;
            sb         <= b;
            res        <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_next;
          res <= res_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state      <= DONE;
            done       <= 1'b1;
            borrow_out <= br_next;
`ifdef SERIAL_SUB_CLAMP_EN
            diff       <= br_next ? '0 : res_next;
`else
            diff       <= res_next;
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial N-bit subtractor built around the half-subtractor primitive. It accepts two WIDTH-bit operands on a start pulse and sequences one bit per clock, LSB first. Each bit goes through two cascaded half-subtractor stages (operand stage, then borrow stage), with the borrow held in a register. It presents the full difference and the final borrow with a one-cycle done pulse, and sits between a requester and any consumer that needs A−B without a parallel subtractor.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while busy=0
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high from the cycle after acceptance through the done cycle
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  difference a−b mod 2^WIDTH; held until next accepted start
- borrow_out  output  1  final borrow (1 when a<b unsigned); held with diff

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - start=1 latches a and b into shift registers, clears the borrow register and the bit counter, and clears diff and borrow_out to 0.
  - Next state is SHIFT.
- SHIFT, per cycle on bit i = counter:
  - Stage 1: t = a_i ^ b_i; br1 = ~a_i & b_i.
  - Stage 2: d = t ^ br; br2 = ~t & br.
  - br ← br1 | br2.
  - d shifts into the result register from the MSB side; the operand registers shift right.
  - The counter increments. When counter = WIDTH−1 the result is complete; next state is DONE.
- DONE:
  - done=1 for exactly one cycle.
  - diff and borrow_out update on the transition into DONE and then hold.
  - Next state is IDLE unconditionally.
- Counter width is clog2(WIDTH)+1 bits and never wraps inside an operation.
- start while busy=1, including the DONE cycle, is ignored and not queued.
- Changes on a or b after acceptance have no effect.
- Reset mid-operation aborts immediately: state IDLE, all registers and outputs 0, and no done pulse.

## Timing
- Reset values: busy=0, done=0, diff=0, borrow_out=0.
- Start accepted on edge 0 gives:
  - busy=1 after edge 0;
  - WIDTH SHIFT cycles on edges 1..WIDTH;
  - DONE entered after edge WIDTH, with done=1 for that cycle;
  - busy=0 after edge WIDTH+1.
- Latency from accepted start to done high is WIDTH+1 cycles (9 for WIDTH=8).
- Throughput is one operation per WIDTH+2 cycles. The earliest next start is accepted on the edge at which busy has returned to 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_SUB_CLAMP_EN
  - Defined: when the final borrow is 1, diff is forced to 0 on entry to DONE. borrow_out still reports 1, acting as the underflow flag.
  - Undefined: diff is the modular two's-complement result.
- The default build leaves the macro undefined.

## Test plan
- WIDTH=8, a=0x05, b=0x03, start pulse → done exactly 9 cycles later; diff=0x02, borrow_out=0; busy=0 on the following cycle.
- a=0x03, b=0x05:
  - without macro → diff=0xFE, borrow_out=1;
  - with SERIAL_SUB_CLAMP_EN → diff=0x00, borrow_out=1.
- Boundary operands:
  - a=0xFF, b=0xFF → diff=0x00, borrow_out=0;
  - a=0x00, b=0x01 → diff=0xFF, borrow_out=1;
  - a=0x80, b=0x7F → diff=0x01, borrow_out=0.
- Start and operand stability during an operation:
  - start held high and a/b changed during SHIFT → single done pulse with the original result;
  - back-to-back start asserted in the cycle after done → second operation accepted, with its done 9 cycles after that cycle.
- Reset mid-operation: rst_n low during SHIFT cycle 4 → busy, done, diff and borrow_out all 0 immediately. After release, a new start completes normally.
- WIDTH=1 corner: a=0, b=1 → done 2 cycles after start, diff=1, borrow_out=1.
